data_mem_responder: RTL

Byte-addressed data memory that answers load and store requests from the pipelined CPU's MEM stage over a valid/ready request channel and a valid/ready response channel. It holds a 512-byte little-endian array, inserts a programmable number of wait states, and flags misaligned word accesses. The CPU issues the requests; this block is the responder side of that channel and replaces the CPU's fixed-latency memory path.

---
 rtl/cpu_mem_pkg.sv | 19 +
 rtl/data_mem_responder_byte_ram.sv | 39 +++
 rtl/data_mem_responder.sv | 136 +++++++++++++
 3 files changed

// File: rtl/cpu_mem_pkg.sv
// Shared types and constants for the CPU data-memory responder.
package cpu_mem_pkg;

  localparam int CNT_W  = 4;
  localparam int WORD_W = 32;
  localparam int BYTE_W = 8;
  localparam int LANES  = WORD_W / BYTE_W;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  function automatic logic misaligned(input logic [1:0] addr_lsb);
    return addr_lsb != 2'b00;
  endfunction

endpackage

// File: rtl/data_mem_responder_byte_ram.sv
// Byte-addressed RAM stored as four byte lanes; lane i holds byte address 4*w+i,
// so an aligned word access maps to one row across all lanes (little-endian).
module byte_ram
  import cpu_mem_pkg::*;
#(
  parameter int ADDR_W = 9
) (
  input  logic                clk_i,
  input  logic [LANES-1:0]    wr_en_i,
  input  logic [ADDR_W-3:0]   word_addr_i,
  input  logic [WORD_W-1:0]   wdata_i,
  input  logic                rd_en_i,
  output logic [WORD_W-1:0]   rdata_o
);

  localparam int DEPTH = 2 ** (ADDR_W - 2);

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      logic [BYTE_W-1:0] bank_q [DEPTH];
      logic [BYTE_W-1:0] rd_q;

      // Read register only moves on rd_en so the word stays stable while the
      // response is stalled.
      always_ff @(posedge clk_i) begin
        if (wr_en_i[gi]) begin
          bank_q[word_addr_i] <= wdata_i[gi*BYTE_W +: BYTE_W];
        end
        if (rd_en_i) begin
          rd_q <= bank_q[word_addr_i];
        end
      end

      assign rdata_o[gi*BYTE_W +: BYTE_W] = rd_q;
    end
  endgenerate

endmodule

// File: rtl/data_mem_responder.sv
// Load/store responder for the CPU MEM stage: valid/ready request and response
// channels, programmable wait states, misaligned-word detection.
module data_mem_responder
  import cpu_mem_pkg::*;
#(
  parameter int ADDR_W  = 9,
  parameter int LATENCY = 2
) (
  input  logic                clka,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [LANES-1:0]    req_be,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [WORD_W-1:0]   req_wdata,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [WORD_W-1:0]   rsp_rdata,
  output logic                rsp_err
);

  localparam logic [CNT_W-1:0] LAT_INIT = CNT_W'(LATENCY);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                we_q, we_d;
  logic [LANES-1:0]    be_q, be_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [WORD_W-1:0]   wdata_q, wdata_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic                rsp_err_q, rsp_err_d;
  logic                rsp_load_q, rsp_load_d;

  logic                commit;
  logic                bad_addr;
  logic [LANES-1:0]    ram_wr_en;
  logic                ram_rd_en;
  logic [WORD_W-1:0]   ram_rdata;

  assign bad_addr = misaligned(addr_q[1:0]);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    be_d        = be_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    rsp_load_d  = rsp_load_q;
    commit      = 1'b0;
    req_ready   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          we_d    = req_we;
          be_d    = req_be;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          cnt_d   = LAT_INIT;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          commit      = 1'b1;
          rsp_valid_d = 1'b1;
          rsp_err_d   = bad_addr;
          rsp_load_d  = !we_q && !bad_addr;
          state_d     = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          rsp_err_d   = 1'b0;
          rsp_load_d  = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      be_q        <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_load_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      be_q        <= be_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_load_q  <= rsp_load_d;
    end
  end

  // Misaligned accesses never touch the array in either direction.
  assign ram_wr_en = (commit && we_q && !bad_addr) ? be_q : '0;
  assign ram_rd_en = commit && !we_q && !bad_addr;

  byte_ram #(
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk_i       (clka),
    .wr_en_i     (ram_wr_en),
    .word_addr_i (addr_q[ADDR_W-1:2]),
    .wdata_i     (wdata_q),
    .rd_en_i     (ram_rd_en),
    .rdata_o     (ram_rdata)
  );

  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_load_q ? ram_rdata : '0;

endmodule
